// File: rtl/emb_table_trainer.sv
// Owns word/context embedding tables and sequences one skip-gram step per request.
// Latency: accept -> resp_valid after 3+EVAL_CYC edges; req_ready returns one cycle later.
// Backpressure: req_ready only in IDLE with no load pending; loads outside IDLE are dropped.
module emb_table_trainer #(
  parameter int DIM      = 3,
  parameter int W        = 16,
  parameter int ADDR_W   = 4,
  parameter int EVAL_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic                load_sel,
  input  logic [ADDR_W-1:0]   load_addr,
  input  logic [DIM*W-1:0]    load_data,
  input  logic                rd_sel,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DIM*W-1:0]    rd_data,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_word_idx,
  input  logic [ADDR_W-1:0]   req_ctx_idx,
  input  logic [W-1:0]        req_y_actual,
  output logic [DIM*W-1:0]    word_embv,
  output logic [DIM*W-1:0]    context_embv,
  output logic [W-1:0]        y_actual,
  input  logic [DIM*W-1:0]    new_word_embv,
  input  logic [DIM*W-1:0]    new_context_embv,
  input  logic [W-1:0]        y,
  input  logic [W-1:0]        error,
  output logic                resp_valid,
  output logic [W-1:0]        resp_y,
  output logic [W-1:0]        resp_error
);

  localparam int VW    = DIM * W;
  localparam int NENT  = 1 << ADDR_W;
  localparam int CNT_W = (EVAL_CYC > 1) ? $clog2(EVAL_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EVAL_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EVAL, S_WRITE, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   widx_q, widx_d, cidx_q, cidx_d;
  logic [W-1:0]        ylab_q, ylab_d;
  logic [VW-1:0]       wemb_q, wemb_d, cemb_q, cemb_d;
  logic [W-1:0]        yact_q, yact_d, ry_q, ry_d, re_q, re_d;
  logic [VW-1:0]       rd_q;

  // Tables are deliberately left out of reset; only the sequencer state is cleared.
  logic [VW-1:0]       wtab_q [NENT];
  logic [VW-1:0]       ctab_q [NENT];

  logic                wtab_we, ctab_we;
  logic [ADDR_W-1:0]   wtab_addr, ctab_addr;
  logic [VW-1:0]       wtab_wdat, ctab_wdat;

  // Next-state, handshake and table-write decode; load wins over a same-cycle request.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    cidx_d     = cidx_q;
    ylab_d     = ylab_q;
    wemb_d     = wemb_q;
    cemb_d     = cemb_q;
    yact_d     = yact_q;
    ry_d       = ry_q;
    re_d       = re_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    wtab_we    = 1'b0;
    ctab_we    = 1'b0;
    wtab_addr  = load_addr;
    ctab_addr  = load_addr;
    wtab_wdat  = load_data;
    ctab_wdat  = load_data;
    case (state_q)
      S_IDLE: begin
        req_ready = !load_en;
        if (load_en) begin
          wtab_we = !load_sel;
          ctab_we = load_sel;
        end else if (req_valid) begin
          widx_d  = req_word_idx;
          cidx_d  = req_ctx_idx;
          ylab_d  = req_y_actual;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        wemb_d  = wtab_q[widx_q];
        cemb_d  = ctab_q[cidx_q];
        yact_d  = ylab_q;
        cnt_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (cnt_q == CNT_LAST) state_d = S_WRITE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      S_WRITE: begin
        wtab_we   = 1'b1;
        ctab_we   = 1'b1;
        wtab_addr = widx_q;
        ctab_addr = cidx_q;
        wtab_wdat = new_word_embv;
        ctab_wdat = new_context_embv;
        ry_d      = y;
        re_d      = error;
        state_d   = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer and presented-vector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      widx_q  <= '0;
      cidx_q  <= '0;
      ylab_q  <= '0;
      wemb_q  <= '0;
      cemb_q  <= '0;
      yact_q  <= '0;
      ry_q    <= '0;
      re_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      widx_q  <= widx_d;
      cidx_q  <= cidx_d;
      ylab_q  <= ylab_d;
      wemb_q  <= wemb_d;
      cemb_q  <= cemb_d;
      yact_q  <= yact_d;
      ry_q    <= ry_d;
      re_q    <= re_d;
    end
  end

  // Table writes; suppressed under reset so an aborted step never writes back.
  always_ff @(posedge clk) begin
    if (!rst && wtab_we) wtab_q[wtab_addr] <= wtab_wdat;
    if (!rst && ctab_we) ctab_q[ctab_addr] <= ctab_wdat;
  end

  // Registered readback; a same-edge write shows up on the following read.
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_sel ? ctab_q[rd_addr] : wtab_q[rd_addr];
  end

  assign rd_data      = rd_q;
  assign word_embv    = wemb_q;
  assign context_embv = cemb_q;
  assign y_actual     = yact_q;
  assign resp_y       = ry_q;
  assign resp_error   = re_q;

endmodule
